// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded instruction fields into 32-bit instruction
// words (opcode in [31:26]), queues them in a small FIFO and drains the FIFO
// into instruction memory through a write port with an auto-incrementing
// address. Program-loader side of the Harvard instruction path.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    in_opcode,
  input  logic [4:0]    in_rd2,
  input  logic [4:0]    in_rd1,
  input  logic [4:0]    in_rs2,
  input  logic [4:0]    in_rs1,
  input  logic [15:0]   in_imm,
  input  logic [7:0]    in_addr,
  input  logic          base_load,
  input  logic [AW-1:0] base_addr,
  input  logic          imem_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          illegal,
  output logic          busy,
  output logic [15:0]   wr_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Returns {legal, word}; opcodes above 0x10 are rejected with a zero word.
  function automatic logic [32:0] encode_word(
    input logic [5:0]  op,
    input logic [4:0]  rd2,
    input logic [4:0]  rd1,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [15:0] imm,
    input logic [7:0]  daddr
  );
    logic [31:0] w;
    logic        ok;
    w  = {op, 26'h0000000};
    ok = 1'b1;
    case (op) inside
      6'h00:         w[25:0] = {rd2, 5'h00, imm};
      6'h01:         w[25:0] = {rd2, 16'h0000, rs2};
      6'h02:         w[25:0] = {rd2, 13'h0000, daddr};
      6'h03:         w[25:0] = {daddr, 13'h0000, rs2};
      [6'h04:6'h10]: w[25:0] = {rd2, rd1, 6'h00, rs2, rs1};
      default: begin
        w  = 32'h0000_0000;
        ok = 1'b0;
      end
    endcase
    return {ok, w};
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] addr_r;
  logic [15:0]   wr_count_r;
  logic          illegal_r;

  logic [32:0]   enc_s;
  logic          legal_s;
  logic          full_s;
  logic          busy_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;

  // Encoding and handshake decode; in_ready depends on occupancy only.
  always_comb begin
    enc_s    = encode_word(in_opcode, in_rd2, in_rd1, in_rs2, in_rs1, in_imm, in_addr);
    legal_s  = enc_s[32];
    full_s   = (count_r == FULL_CNT);
    busy_s   = (count_r != {CW{1'b0}});
    accept_s = in_valid && !full_s;
    push_s   = accept_s && legal_s;
    pop_s    = busy_s && imem_ready;
  end

  // FIFO storage; contents are only visible through the busy-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= enc_s[31:0];
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Write address: base_load only while idle, otherwise advance per write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {AW{1'b0}};
    end else if (base_load && !busy_s) begin
      addr_r <= base_addr;
    end else if (pop_s) begin
      addr_r <= addr_r + 1'b1;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Saturating write counter and one-cycle illegal-opcode pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_r <= 16'h0000;
      illegal_r  <= 1'b0;
    end else begin
      illegal_r <= accept_s && !legal_s;
      if (pop_s && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'h0001;
      end else begin
        wr_count_r <= wr_count_r;
      end
    end
  end

  assign in_ready   = !full_s;
  assign busy       = busy_s;
  assign imem_we    = busy_s;
  assign imem_addr  = addr_r;
  assign imem_wdata = busy_s ? mem_r[rd_ptr_r] : 32'h0000_0000;
  assign illegal    = illegal_r;
  assign wr_count   = wr_count_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus a random
// run compared against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_opcode;
  logic [4:0]    in_rd2, in_rd1, in_rs2, in_rs1;
  logic [15:0]   in_imm;
  logic [7:0]    in_addr;
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          imem_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          illegal;
  logic          busy;
  logic [15:0]   wr_count;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd2(in_rd2), .in_rd1(in_rd1), .in_rs2(in_rs2),
    .in_rs1(in_rs1), .in_imm(in_imm), .in_addr(in_addr), .base_load(base_load),
    .base_addr(base_addr), .imem_ready(imem_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .illegal(illegal),
    .busy(busy), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_enc(int op, int rd2, int rd1, int rs2, int rs1, int imm, int da);
    longint w;
    w = longint'(op) * 64'd67108864;
    if (op == 0)                  w += rd2 * 2097152 + imm;
    else if (op == 1)             w += rd2 * 2097152 + rs2;
    else if (op == 2)             w += rd2 * 2097152 + da;
    else if (op == 3)             w += da * 262144 + rs2;
    else if (op >= 4 && op <= 16) w += rd2 * 2097152 + rd1 * 65536 + rs2 * 32 + rs1;
    else                          w = 0;
    return 32'(w);
  endfunction

  task automatic set_idle();
    in_valid = 1'b0; in_opcode = 6'h00; in_rd2 = 5'h00; in_rd1 = 5'h00;
    in_rs2 = 5'h00; in_rs1 = 5'h00; in_imm = 16'h0000; in_addr = 8'h00;
    base_load = 1'b0; base_addr = 8'h00;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd2, input logic [4:0] rd1,
                       input logic [4:0] rs2, input logic [4:0] rs1,
                       input logic [15:0] imm, input logic [7:0] da);
    in_valid = 1'b1; in_opcode = op; in_rd2 = rd2; in_rd1 = rd1;
    in_rs2 = rs2; in_rs1 = rs1; in_imm = imm; in_addr = da;
  endtask

  task automatic do_reset();
    set_idle();
    imem_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0 ||
        illegal !== 1'b0 || busy !== 1'b0 || wr_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b addr=%h wdata=%h ill=%b busy=%b cnt=%h, required 1 0 00 0 0 0 0",
               in_ready, imem_we, imem_addr, imem_wdata, illegal, busy, wr_count);
    end
  endtask

  task automatic test_encode();
    do_reset();
    @(posedge clk); #1 drive(6'h04, 5'd3, 5'd7, 5'd1, 5'd2, 16'h0, 8'h0);
    @(posedge clk); #1 set_idle();
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h10670022) begin
      errors++;
      $display("FAIL rtype_word: we=%b addr=%h data=%h, required 1 00 10670022", imem_we, imem_addr, imem_wdata);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (wr_count !== 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rtype_count: cnt=%0d busy=%b, required 1 0", wr_count, busy);
    end
    do_reset();
    @(posedge clk); #1 drive(6'h00, 5'd5, 5'd0, 5'd0, 5'd0, 16'hBEEF, 8'h0);
    @(posedge clk); #1 drive(6'h03, 5'd0, 5'd0, 5'd9, 5'd0, 16'h0, 8'hA5);
    @(negedge clk);
    checks++;
    if (imem_addr !== 8'h00 || imem_wdata !== 32'h00A0BEEF) begin
      errors++;
      $display("FAIL li_word: addr=%h data=%h, required 00 00A0BEEF", imem_addr, imem_wdata);
    end
    @(posedge clk); #1 set_idle();
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h01 || imem_wdata !== 32'h0E940009) begin
      errors++;
      $display("FAIL store_word: we=%b addr=%h data=%h, required 1 01 0E940009", imem_we, imem_addr, imem_wdata);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (wr_count !== 16'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pair_count: cnt=%0d busy=%b, required 2 0", wr_count, busy);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    @(posedge clk); #1 drive(6'h12, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 8'h56);
    @(posedge clk); #1 set_idle();
    @(negedge clk);
    checks++;
    if (illegal !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse: ill=%b we=%b rdy=%b, required 1 0 1", illegal, imem_we, in_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (illegal !== 1'b0 || wr_count !== 16'd0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after: ill=%b cnt=%0d we=%b, required 0 0 0", illegal, wr_count, imem_we);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_w [4];
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 drive(6'h05, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i + 4), 16'h0, 8'h0);
      exp_w[i] = ref_enc(5, i + 1, i + 2, i + 3, i + 4, 0, 0);
    end
    @(posedge clk); #1 drive(6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 16'hDEAD, 8'h0);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || imem_wdata !== exp_w[0]) begin
      errors++;
      $display("FAIL full_ready: rdy=%b busy=%b head=%h, required 0 1 %h", in_ready, busy, imem_wdata, exp_w[0]);
    end
    @(posedge clk); #1 begin set_idle(); imem_ready = 1'b1; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_wdata !== exp_w[i]) begin
        errors++;
        $display("FAIL drain_%0d: we=%b addr=%h data=%h, required 1 %h %h", i, imem_we, imem_addr, imem_wdata, 8'(i), exp_w[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_count !== 16'd4 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: busy=%b cnt=%0d rdy=%b, required 0 4 1", busy, wr_count, in_ready);
    end
  endtask

  task automatic test_base_load();
    logic [7:0] exp_a [3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
    do_reset();
    @(posedge clk); #1 begin drive(6'h02, 5'd1, 5'd0, 5'd0, 5'd0, 16'h0, 8'h10); base_load = 1'b1; base_addr = 8'hFE; end
    @(posedge clk); #1 begin drive(6'h02, 5'd2, 5'd0, 5'd0, 5'd0, 16'h0, 8'h11); base_load = 1'b0; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== exp_a[i] || imem_wdata !== ref_enc(2, i + 1, 0, 0, 0, 0, 16 + i)) begin
        errors++;
        $display("FAIL base_wr_%0d: we=%b addr=%h data=%h, required 1 %h %h", i, imem_we, imem_addr, imem_wdata,
                 exp_a[i], ref_enc(2, i + 1, 0, 0, 0, 0, 16 + i));
      end
      @(posedge clk);
      #1 if (i == 0) drive(6'h02, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0, 8'h12); else set_idle();
    end
    imem_ready = 1'b0;
    drive(6'h01, 5'd4, 5'd0, 5'd6, 5'd0, 16'h0, 8'h0);
    @(posedge clk); #1 begin set_idle(); base_load = 1'b1; base_addr = 8'h40; end
    @(posedge clk); #1 base_load = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== 8'h01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL base_busy: addr=%h busy=%b, required 01 1", imem_addr, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b0;
    @(posedge clk); #1 begin drive(6'h00, 5'd1, 5'd0, 5'd0, 5'd0, 16'h1111, 8'h0); base_load = 1'b1; base_addr = 8'h33; end
    @(posedge clk); #1 begin drive(6'h00, 5'd2, 5'd0, 5'd0, 5'd0, 16'h2222, 8'h0); base_load = 1'b0; end
    @(posedge clk); #1 set_idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_we !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: we=%b busy=%b addr=%h data=%h, required 0 0 00 0", imem_we, busy, imem_addr, imem_wdata);
    end
    @(posedge clk); #1 begin rst_n = 1'b1; imem_ready = 1'b1; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || wr_count !== 16'd0) begin
        errors++;
        $display("FAIL stale_write_%0d: we=%b cnt=%0d, required 0 0", i, imem_we, wr_count);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int m_addr, m_cnt, m_ill;
    int op, pre_size;
    logic acc;
    do_reset();
    m_addr = 0; m_cnt = 0; m_ill = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (imem_we !== (q.size() > 0) || busy !== (q.size() > 0) || in_ready !== (q.size() < DEPTH) ||
          imem_addr !== 8'(m_addr) || imem_wdata !== ((q.size() > 0) ? q[0] : 32'h0) ||
          illegal !== 1'(m_ill) || wr_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random_cyc%0d: we=%b rdy=%b addr=%h data=%h ill=%b cnt=%0d, required we=%b rdy=%b addr=%h data=%h ill=%0d cnt=%0d",
                 cyc, imem_we, in_ready, imem_addr, imem_wdata, illegal, wr_count, q.size() > 0,
                 q.size() < DEPTH, 8'(m_addr), (q.size() > 0) ? q[0] : 32'h0, m_ill, m_cnt);
      end
      // advance the model with the inputs that the coming edge will see
      op = int'(in_opcode);
      pre_size = q.size();
      acc = in_valid && (pre_size < DEPTH);
      m_ill = (acc && op > 16) ? 1 : 0;
      if (pre_size > 0 && imem_ready) begin
        void'(q.pop_front());
        m_addr = (m_addr + 1) % 256;
        if (m_cnt < 65535) m_cnt++;
      end
      if (base_load && pre_size == 0) m_addr = int'(base_addr);
      if (acc && op <= 16)
        q.push_back(ref_enc(op, int'(in_rd2), int'(in_rd1), int'(in_rs2), int'(in_rs1), int'(in_imm), int'(in_addr)));
      @(posedge clk);
      #1;
      in_valid   = ($urandom_range(0, 3) != 0);
      in_opcode  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(17, 63)) : 6'($urandom_range(0, 16));
      in_rd2     = 5'($urandom); in_rd1 = 5'($urandom);
      in_rs2     = 5'($urandom); in_rs1 = 5'($urandom);
      in_imm     = 16'($urandom); in_addr = 8'($urandom);
      imem_ready = ($urandom_range(0, 2) != 0);
      base_load  = ($urandom_range(0, 7) == 0);
      base_addr  = 8'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b1;
    set_idle();
    test_reset();
    test_encode();
    test_illegal();
    test_full();
    test_base_load();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
